// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port framebuffer RAM between the VGA scanout pixel fetch
// and a writer port (CPU or pattern generator). Scanout has priority. A
// bounded-wait counter forces a writer slot once the writer has waited
// MAX_WAIT cycles, so writes still make progress during long active-video
// runs. Every memory-side output is registered.
//
// Timing, with the decision made in cycle N from cycle-N inputs:
//   N+1 : RAM command on mem_* (read or write), wr_ack for a write grant,
//         disp_miss if a forced writer slot displaced a scanout request
//   N+2 : disp_valid / disp_rdata for a scanout read
//
// Parameters:
//   ADDR_W   framebuffer address width (default 15)
//   DATA_W   framebuffer data width (default 8)
//   MAX_WAIT writer wait cycles before a forced grant, 1..255 (default 16)
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   disp_req     scanout read request, single-cycle
//   disp_addr    scanout read address, valid with disp_req
//   disp_valid   disp_rdata valid
//   disp_rdata   scanout read data, holds its last value while disp_valid=0
//   disp_miss    scanout request displaced by a forced writer slot
//   wr_req       writer request, held until wr_ack
//   wr_addr      writer address
//   wr_data      writer data
//   wr_ack       write committed, one-cycle pulse
//   mem_en       RAM enable
//   mem_we       RAM write enable
//   mem_addr     RAM address (holds when idle)
//   mem_wdata    RAM write data (holds when not writing)
//   mem_rdata    RAM read data, valid one cycle after a read command
//
// Optional feature, enabled by defining VGA_FB_ARB_STATS_EN:
//   stats_clr    synchronous clear of miss_count (wins over an increment)
//   miss_count   saturating 16-bit count of disp_miss pulses
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_miss,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       miss_count
`endif
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0]        wait_cnt;
  logic              rd_pend;
  logic [DATA_W-1:0] rdata_hold;

  logic cand_wr;
  logic forced;
  logic grant_wr;
  logic grant_disp;

  // A request still held during its own ack cycle is the completed write,
  // not a new one, so it is masked out of the candidate set.
  always_comb begin
    cand_wr    = wr_req & ~wr_ack;
    forced     = cand_wr & (wait_cnt == WAIT_LIMIT);
    grant_wr   = cand_wr & (~disp_req | forced);
    grant_disp = disp_req & ~forced;
  end

  // Bounded-wait counter: counts cycles a candidate writer was passed over.
  // During the ack cycle wr_req may still be high but the writer is not a
  // candidate, so the counter simply holds (it was cleared by the grant).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (!wr_req || grant_wr) begin
      wait_cnt <= 8'd0;
    end else if (cand_wr && (wait_cnt != WAIT_LIMIT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // RAM command stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      disp_miss <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      mem_en    <= grant_wr | grant_disp;
      mem_we    <= grant_wr;
      wr_ack    <= grant_wr;
      disp_miss <= forced & disp_req;
      rd_pend   <= grant_disp;
      if (grant_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (grant_disp) begin
        mem_addr  <= disp_addr;
      end
    end
  end

  // Read return stage. The RAM data only exists during the cycle after the
  // read command, so disp_rdata passes it straight through while valid and
  // otherwise shows the last returned pixel from the hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_valid <= 1'b0;
      rdata_hold <= '0;
    end else begin
      disp_valid <= rd_pend;
      if (disp_valid) begin
        rdata_hold <= mem_rdata;
      end
    end
  end

  assign disp_rdata = disp_valid ? mem_rdata : rdata_hold;

`ifdef VGA_FB_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count <= 16'd0;
    end else if (stats_clr) begin
      miss_count <= 16'd0;
    end else if (disp_miss && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
